branch_pred_ctrl: RTL and testbench

// - ID-stage branch prediction and redirect controller for the 5-stage RV32 pipeline.
// - Consumes the decoded immediate and instruction word in ID and predicts conditional branches with a 2-bit PHT.
// - JAL is always predicted taken.
// - Checks EX-stage resolution, trains the PHT, and sequences misprediction recovery.
// - Recovery outputs: redirect PC plus IF/ID and ID/EX flushes.

---
 rtl/rv_pkg.sv | 30 +++
 rtl/pht_2bit.sv | 31 +++
 rtl/branch_pred_ctrl.sv | 132 +++++++++++++
 tb/tb_branch_pred_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared opcodes, PHT counter encodings and predictor FSM states
package rv_pkg;

    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_REG = 7'b0110011;

    typedef enum logic [1:0] {
        SN = 2'b00,
        WN = 2'b01,
        WT = 2'b10,
        ST = 2'b11
    } pht_state_e;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } fsm_state_e;

    // Saturating 2-bit counter step toward the resolved outcome.
    function automatic logic [1:0] pht_next(input logic [1:0] cur, input logic taken);
        if (taken) begin
            return (cur == ST) ? cur : cur + 2'd1;
        end
        return (cur == SN) ? cur : cur - 2'd1;
    endfunction

endpackage

// File: rtl/pht_2bit.sv
// rtl/pht_2bit.sv - 2-bit pattern history table, async read, one sync update port
module pht_2bit
    import rv_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_cnt_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    logic [1:0] pht_q [2**IDX_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**IDX_W; i++) begin
                pht_q[i] <= WN;
            end
        end else if (upd_en_i) begin
            pht_q[upd_idx_i] <= pht_next(pht_q[upd_idx_i], upd_taken_i);
        end
    end

    // Read sees the stored value, so a same-cycle update is not forwarded.
    assign rd_cnt_o = pht_q[rd_idx_i];

endmodule

// File: rtl/branch_pred_ctrl.sv
// rtl/branch_pred_ctrl.sv - ID-stage branch predictor with EX-resolved redirect and recovery FSM
module branch_pred_ctrl
    import rv_pkg::*;
#(
    parameter int PHT_IDX_W   = 6,
    parameter int RECOVER_CYC = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             id_valid,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_ir,
    input  logic [31:0]      id_imm,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_target,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int RC_W = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RECOVER_CYC - 1);

    fsm_state_e       state_q, state_d;
    logic [RC_W-1:0]  rc_cnt_q, rc_cnt_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] mispred_count_q, mispred_count_d;

    logic       ex_resolve;
    logic       mispredict;
    logic [1:0] id_cnt;
    logic       pred_raw;
    logic       unused_ir;

    assign ex_resolve = ex_valid & ex_is_branch & ~stall;
    assign mispredict = ex_resolve & (ex_taken != ex_pred_taken);
    assign unused_ir  = ^id_ir[31:7];

    pht_2bit #(
        .IDX_W(PHT_IDX_W)
    ) u_pht (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_idx_i    (id_pc[PHT_IDX_W+1:2]),
        .rd_cnt_o    (id_cnt),
        .upd_en_i    (ex_resolve),
        .upd_idx_i   (ex_pc[PHT_IDX_W+1:2]),
        .upd_taken_i (ex_taken)
    );

    always_comb begin
        pred_raw = 1'b0;
        case (id_ir[6:0])
            OP_JAL:                 pred_raw = 1'b1;
            OP_B:                   pred_raw = id_cnt[1];
            OP_LW, OP_SW, OP_REG:   pred_raw = 1'b0;
            default:                pred_raw = 1'b0;
        endcase
    end

    // rst_n gate keeps a JAL in ID from predicting while the block is held in reset.
    assign pred_taken  = rst_n & id_valid & (state_q == RUN) & pred_raw;
    assign pred_target = id_pc + id_imm;

    always_comb begin
        state_d          = state_q;
        rc_cnt_d         = rc_cnt_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        br_count_d       = br_count_q;
        mispred_count_d  = mispred_count_q;
        if (!stall) begin
            redirect_valid_d = mispredict;
            if (mispredict) begin
                redirect_pc_d = ex_taken ? ex_target : ex_pc + 32'd4;
                state_d       = RECOVER;
                rc_cnt_d      = RC_LOAD;
            end else if (state_q == RECOVER) begin
                if (rc_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    rc_cnt_d = rc_cnt_q - RC_W'(1);
                end
            end
            if (ex_resolve && br_count_q != '1) begin
                br_count_d = br_count_q + CNT_W'(1);
            end
            if (mispredict && mispred_count_q != '1) begin
                mispred_count_d = mispred_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= RUN;
            rc_cnt_q         <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            br_count_q       <= '0;
            mispred_count_q  <= '0;
        end else begin
            state_q          <= state_d;
            rc_cnt_q         <= rc_cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            br_count_q       <= br_count_d;
            mispred_count_q  <= mispred_count_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign flush_if_id    = redirect_valid_q;
    assign flush_id_ex    = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign br_count       = br_count_q;
    assign mispred_count  = mispred_count_q;

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// tb/tb_branch_pred_ctrl.sv - scoreboard bench for branch_pred_ctrl
module tb_branch_pred_ctrl;

    localparam logic [31:0] IR_B   = 32'h0000_0063;
    localparam logic [31:0] IR_JAL = 32'h0000_006F;

    localparam int S_PT  = 0;
    localparam int S_PTG = 1;
    localparam int S_RV  = 2;
    localparam int S_RPC = 3;
    localparam int S_FIF = 4;
    localparam int S_FIX = 5;
    localparam int S_BRC = 6;
    localparam int S_MPC = 7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_pc, id_ir, id_imm;
    logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_if_id, flush_id_ex;
    logic [15:0] br_count, mispred_count;

    typedef struct {
        int          sel;
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    branch_pred_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_ir         (id_ir),
        .id_imm        (id_imm),
        .ex_valid      (ex_valid),
        .ex_is_branch  (ex_is_branch),
        .ex_pc         (ex_pc),
        .ex_taken      (ex_taken),
        .ex_pred_taken (ex_pred_taken),
        .ex_target     (ex_target),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic exp_push(input int sel, input string tag, input logic [31:0] v);
        exp_t e;
        e.sel = sel;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] act;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                S_PT:    act = {31'd0, pred_taken};
                S_PTG:   act = pred_target;
                S_RV:    act = {31'd0, redirect_valid};
                S_RPC:   act = redirect_pc;
                S_FIF:   act = {31'd0, flush_if_id};
                S_FIX:   act = {31'd0, flush_id_ex};
                S_BRC:   act = {16'd0, br_count};
                default: act = {16'd0, mispred_count};
            endcase
            check_val(e.tag, act, e.exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] ir, input logic [31:0] imm);
        id_valid = v;
        id_pc    = pc;
        id_ir    = ir;
        id_imm   = imm;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic tk, input logic pr, input logic [31:0] tgt);
        ex_valid      = v;
        ex_is_branch  = v;
        ex_pc         = pc;
        ex_taken      = tk;
        ex_pred_taken = pr;
        ex_target     = tgt;
    endtask

    task automatic idle();
        stall = 1'b0;
        set_id(1'b0, 32'd0, 32'd0, 32'd0);
        set_ex(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        // Reset with a JAL presented in ID
        set_id(1'b1, 32'h100, IR_JAL, 32'h20);
        exp_push(S_PT, "rst_pt", 0);
        exp_push(S_RV, "rst_rv", 0);
        exp_push(S_RPC, "rst_rpc", 0);
        exp_push(S_FIF, "rst_fif", 0);
        exp_push(S_BRC, "rst_brc", 0);
        exp_push(S_MPC, "rst_mpc", 0);
        cycle();
        rst_n = 1'b1;

        exp_push(S_PT, "jal_pt", 1);
        exp_push(S_PTG, "jal_tgt", 32'h120);
        cycle();

        // Train PHT[16] taken twice, reading the same index in ID
        set_id(1'b1, 32'h40, IR_B, 32'h10);
        set_ex(1'b1, 32'h40, 1'b1, 1'b1, 32'h50);
        exp_push(S_PT, "wn_pt", 0);
        cycle();
        exp_push(S_PT, "wt_rbw_pt", 1);
        cycle();
        set_ex(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        exp_push(S_PT, "st_pt", 1);
        exp_push(S_BRC, "br2", 2);
        exp_push(S_RV, "no_rv", 0);
        exp_push(S_MPC, "mp0", 0);
        cycle();

        // Taken mispredict at 0x80
        idle();
        set_ex(1'b1, 32'h80, 1'b1, 1'b0, 32'h60);
        exp_push(S_RV, "pre_rv", 0);
        cycle();
        idle();
        set_id(1'b1, 32'h40, IR_B, 32'h10);
        exp_push(S_PT, "rec1_pt", 0);
        exp_push(S_RV, "mp_rv", 1);
        exp_push(S_FIF, "mp_fif", 1);
        exp_push(S_FIX, "mp_fix", 1);
        exp_push(S_RPC, "mp_rpc", 32'h60);
        exp_push(S_MPC, "mp_cnt1", 1);
        exp_push(S_BRC, "br3", 3);
        cycle();
        exp_push(S_PT, "rec2_pt", 0);
        exp_push(S_RV, "pulse_end", 0);
        exp_push(S_FIX, "fix_end", 0);
        cycle();
        set_id(1'b1, 32'h80, IR_B, 32'h10);
        exp_push(S_PT, "run_wt80_pt", 1);
        exp_push(S_RPC, "rpc_hold", 32'h60);
        cycle();

        // Not-taken mispredict with wrapping fall-through
        idle();
        set_ex(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h10);
        cycle();
        idle();
        set_id(1'b1, 32'hFFFF_FFF0, IR_JAL, 32'h20);
        exp_push(S_PT, "wrap_rec_pt", 0);
        exp_push(S_PTG, "wrap_ptg", 32'h10);
        exp_push(S_RV, "wrap_rv", 1);
        exp_push(S_RPC, "wrap_rpc", 32'h0);
        exp_push(S_MPC, "mp_cnt2", 2);
        exp_push(S_BRC, "br4", 4);
        cycle();
        idle();
        cycle();
        set_id(1'b1, 32'h0, IR_JAL, 32'h4);
        exp_push(S_PT, "wrap_run_pt", 1);
        cycle();

        // Stall held while a not-taken mispredict sits in EX
        idle();
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            set_id(1'b1, 32'h40, IR_B, 32'h10);
            set_ex(1'b1, 32'h40, 1'b0, 1'b1, 32'h99);
            exp_push(S_PT, "stall_pt", 1);
            exp_push(S_RV, "stall_rv", 0);
            if (i == 2) begin
                exp_push(S_BRC, "stall_brc", 4);
                exp_push(S_MPC, "stall_mpc", 2);
            end
            cycle();
        end
        stall = 1'b0;
        exp_push(S_PT, "unstall_pt", 1);
        cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            exp_push(S_RV, "held_rv", 1);
            exp_push(S_FIF, "held_fif", 1);
            exp_push(S_RPC, "held_rpc", 32'h44);
            cycle();
        end
        stall = 1'b0;
        exp_push(S_RV, "fall_rv", 1);
        exp_push(S_MPC, "mp_cnt3", 3);
        exp_push(S_BRC, "br5", 5);
        cycle();
        set_id(1'b1, 32'h40, IR_B, 32'h10);
        exp_push(S_RV, "after_rv", 0);
        exp_push(S_PT, "stall_rec_pt", 0);
        cycle();
        exp_push(S_PT, "pht_wt_pt", 1);
        cycle();

        // Reset asserted during recovery
        idle();
        set_ex(1'b1, 32'h200, 1'b1, 1'b0, 32'h300);
        cycle();
        idle();
        exp_push(S_RV, "pre_rst_rv", 1);
        exp_push(S_RPC, "pre_rst_rpc", 32'h300);
        cycle();
        idle();
        set_ex(1'b1, 32'h400, 1'b1, 1'b0, 32'h500);
        cycle();
        rst_n = 1'b0;
        set_ex(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        set_id(1'b1, 32'h100, IR_JAL, 32'h20);
        exp_push(S_PT, "mrst_pt", 0);
        exp_push(S_RV, "mrst_rv", 0);
        exp_push(S_FIX, "mrst_fix", 0);
        exp_push(S_RPC, "mrst_rpc", 0);
        exp_push(S_BRC, "mrst_brc", 0);
        exp_push(S_MPC, "mrst_mpc", 0);
        cycle();
        rst_n = 1'b1;
        exp_push(S_PT, "mrst_run_pt", 1);
        cycle();
        set_id(1'b1, 32'h80, IR_B, 32'h10);
        exp_push(S_PT, "mrst_wn80", 0);
        cycle();
        set_id(1'b1, 32'h40, IR_B, 32'h10);
        exp_push(S_PT, "mrst_wn40", 0);
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
